// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan: digit/guess/warning inputs and the scanned
// anode/segment outputs.
interface seg_scan_if;
    logic [19:0] num_in;
    logic [3:0]  times_in;
    logic        warn_in;
    logic [7:0]  an;
    logic [7:0]  seg;

    modport master (
        output num_in,
        output times_in,
        output warn_in,
        input  an,
        input  seg
    );

    modport slave (
        input  num_in,
        input  times_in,
        input  warn_in,
        output an,
        output seg
    );
endinterface

// File: rtl/seg_scan.sv
// 8-digit multiplexed 7-segment scanner: five BCD guess digits, blank, and a
// two-digit remaining-guess count, with frame-aligned snapshots and warning blink.
module seg_scan #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic [19:0]        num_s_q, num_s_d;
    logic [3:0]         times_s_q, times_s_d;
    logic               warn_s_q, warn_s_d;
    logic               first_q, first_d;
    logic [7:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    logic               tick_c;
    logic               frame_end_c;
    logic               load_c;
    logic [3:0]         units_c;
    logic [6:0]         glyph_c;

    // BCD glyphs; codes above 9 render as a dash.
    function automatic logic [6:0] enc_digit(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h40;
        endcase
        return g;
    endfunction

    // Scan timing, frame-aligned snapshot and blink bookkeeping.
    always_comb begin
        tick_c      = (scan_cnt_q == SCAN_LAST);
        frame_end_c = tick_c && (idx_q == 3'd7);
        load_c      = first_q || frame_end_c;

        scan_cnt_d  = tick_c ? '0 : SCAN_W'(scan_cnt_q + 1'b1);
        idx_d       = tick_c ? 3'(idx_q + 3'd1) : idx_q;
        first_d     = 1'b0;

        num_s_d     = load_c ? bus.num_in   : num_s_q;
        times_s_d   = load_c ? bus.times_in : times_s_q;
        warn_s_d    = load_c ? bus.warn_in  : warn_s_q;

        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        // Idle warning parks the blink phase so a new warning opens visible.
        if (!warn_s_q) begin
            frame_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_end_c) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = FRAME_W'(frame_cnt_q + 1'b1);
            end
        end
    end

    // Glyph for the digit slot currently selected by idx.
    always_comb begin
        units_c = (times_s_q >= 4'd10) ? 4'(times_s_q - 4'd10) : times_s_q;
        case (idx_q)
            3'd0:    glyph_c = enc_digit(num_s_q[19:16]);
            3'd1:    glyph_c = enc_digit(num_s_q[15:12]);
            3'd2:    glyph_c = enc_digit(num_s_q[11:8]);
            3'd3:    glyph_c = enc_digit(num_s_q[7:4]);
            3'd4:    glyph_c = enc_digit(num_s_q[3:0]);
            3'd6:    glyph_c = (times_s_q >= 4'd10) ? 7'h06 : 7'h00;
            3'd7:    glyph_c = enc_digit(units_c);
            default: glyph_c = 7'h00;
        endcase

        an_d  = 8'b0000_0001 << idx_q;
        seg_d = {1'b0, (warn_s_q && !blink_on_q) ? 7'h00 : glyph_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            num_s_q     <= '0;
            times_s_q   <= '0;
            warn_s_q    <= 1'b0;
            first_q     <= 1'b1;
            an_q        <= '0;
            seg_q       <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            num_s_q     <= num_s_d;
            times_s_q   <= times_s_d;
            warn_s_q    <= warn_s_d;
            first_q     <= first_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with SCAN_DIV=4, BLINK_FRAMES=2: expected
// digit slots are queued from the inputs and checked mid-slot.
module tb_seg_scan;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    seg_scan_if dif ();

    seg_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    // Edges since reset release; slot k is stable after edge 4k+3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0: g = 8'h3F;  4'd1: g = 8'h06;  4'd2: g = 8'h5B;  4'd3: g = 8'h4F;
            4'd4: g = 8'h66;  4'd5: g = 8'h6D;  4'd6: g = 8'h7D;  4'd7: g = 8'h07;
            4'd8: g = 8'h7F;  4'd9: g = 8'h6F;  default: g = 8'h40;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] exp_digit(input int k, input logic [19:0] num,
                                             input logic [3:0] times);
        logic [3:0] nib;
        logic [7:0] r;
        if (k < 5) begin
            nib = 4'(num >> (16 - 4 * k));
            r   = enc(nib);
        end else if (k == 5) begin
            r = 8'h00;
        end else if (k == 6) begin
            r = (times >= 4'd10) ? 8'h06 : 8'h00;
        end else begin
            r = enc(4'(times % 4'd10));
        end
        return r;
    endfunction

    task automatic push_frame(input logic [19:0] num, input logic [3:0] times, input bit blank);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.an  = 8'(1 << k);
            e.seg = blank ? 8'h00 : exp_digit(k, num, times);
            sb_q.push_back(e);
        end
    endtask

    // Advance to the next mid-slot sampling point, bounded.
    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (edge_n % 4 == 3) ok = 1'b1;
        end
    endtask

    task automatic reset_release(input logic [19:0] num, input logic [3:0] times, input logic warn);
        rst_n = 1'b0;
        sb_q.delete();
        dif.num_in   = num;
        dif.times_in = times;
        dif.warn_in  = warn;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dif.num_in = 20'h12345; dif.times_in = 4'd7; dif.warn_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dif.an !== 8'h00) $display("FAIL reset_an: got %h want 00", dif.an);
        else n_pass++;
        n_checks++;
        if (dif.seg !== 8'h00) $display("FAIL reset_seg: got %h want 00", dif.seg);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dif.an !== 8'h01 || dif.seg !== 8'h3F)
            $display("FAIL release_first: got an=%h seg=%h want an=01 seg=3F", dif.an, dif.seg);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (dif.an !== 8'h01 || dif.seg !== 8'h06)
            $display("FAIL release_second: got an=%h seg=%h want an=01 seg=06", dif.an, dif.seg);
        else n_pass++;
    endtask

    task automatic test_digits(input logic [19:0] num, input logic [3:0] times, input string tag);
        bit   ok;
        exp_t e;
        reset_release(num, times, 1'b0);
        push_frame(num, times, 1'b0);
        for (int s = 0; s < 8; s++) begin
            wait_sample(ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok || dif.an !== e.an || dif.seg !== e.seg)
                $display("FAIL %s slot %0d: got an=%h seg=%h want an=%h seg=%h (sync=%0d)",
                         tag, s, dif.an, dif.seg, e.an, e.seg, ok);
            else n_pass++;
        end
    endtask

    task automatic test_no_tearing;
        bit   ok;
        exp_t e;
        reset_release(20'h12345, 4'd7, 1'b0);
        push_frame(20'h12345, 4'd7, 1'b0);
        push_frame(20'h54321, 4'd7, 1'b0);
        for (int s = 0; s < 16; s++) begin
            wait_sample(ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok || dif.an !== e.an || dif.seg !== e.seg)
                $display("FAIL tearing slot %0d: got an=%h seg=%h want an=%h seg=%h",
                         s, dif.an, dif.seg, e.an, e.seg);
            else n_pass++;
            if (s == 2) dif.num_in = 20'h54321;
        end
    endtask

    task automatic test_blink;
        bit   ok;
        exp_t e;
        reset_release(20'h24680, 4'd11, 1'b1);
        for (int f = 0; f < 8; f++) push_frame(20'h24680, 4'd11, (f == 2 || f == 3));
        for (int s = 0; s < 64; s++) begin
            wait_sample(ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok || dif.an !== e.an || dif.seg !== e.seg)
                $display("FAIL blink frame %0d digit %0d: got an=%h seg=%h want an=%h seg=%h",
                         s / 8, s % 8, dif.an, dif.seg, e.an, e.seg);
            else n_pass++;
            if (s == 40) dif.warn_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        bit   ok;
        exp_t e;
        reset_release(20'h12345, 4'd7, 1'b0);
        push_frame(20'h12345, 4'd7, 1'b0);
        for (int s = 0; s < 6; s++) begin
            wait_sample(ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok || dif.an !== e.an || dif.seg !== e.seg)
                $display("FAIL pre_reset slot %0d: got an=%h seg=%h want an=%h seg=%h",
                         s, dif.an, dif.seg, e.an, e.seg);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dif.an !== 8'h00 || dif.seg !== 8'h00)
            $display("FAIL async_reset: got an=%h seg=%h want an=00 seg=00", dif.an, dif.seg);
        else n_pass++;
        sb_q.delete();
        dif.num_in = 20'h98765;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dif.an !== 8'h00) $display("FAIL held_reset_an: got %h want 00", dif.an);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dif.an !== 8'h01 || dif.seg !== 8'h3F)
            $display("FAIL rerelease_first: got an=%h seg=%h want an=01 seg=3F", dif.an, dif.seg);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (dif.an !== 8'h01 || dif.seg !== 8'h6F)
            $display("FAIL rerelease_second: got an=%h seg=%h want an=01 seg=6F", dif.an, dif.seg);
        else n_pass++;
    endtask

    initial begin
        dif.num_in   = '0;
        dif.times_in = '0;
        dif.warn_in  = 1'b0;
        test_reset();
        test_digits(20'h12345, 4'd7,  "digits");
        test_digits(20'h12345, 4'd12, "times12");
        test_digits(20'h12345, 4'd0,  "times0");
        test_digits(20'h67890, 4'd15, "times15");
        test_digits(20'h1F3A0, 4'd9,  "dash");
        test_no_tearing();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit slot (minimum 2).
REQ-002 Parameter BLINK_FRAMES, default 125: full 8-digit frames per blink half-period (minimum 1).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 num_in  input  20  five BCD digits: [19:16] oldest/leftmost, [3:0] newest.
REQ-007 times_in  input  4  remaining-guess count, 0..15 binary.
REQ-008 warn_in  input  1  duplicate-digit warning level.
REQ-009 an  output  8  one-hot digit enable, active-high; an[0] is leftmost.
REQ-010 seg  output  8  segments, active-high, {dp,g,f,e,d,c,b,a}.

Function
REQ-011 scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted in the cycle where scan_cnt==SCAN_DIV-1.
REQ-012 On tick, idx (3 bits) SHALL advance by 1 mod 8; 7 wraps to 0 (frame end).
REQ-013 Snapshot registers (num_s, times_s, warn_s) SHALL load from the inputs on the tick where idx==7, and also in the first clk edge after rst_n deasserts; inputs are otherwise ignored (no mid-frame tearing).
REQ-014 an and seg SHALL be registered, reflecting the idx and snapshot values of the previous cycle (1-cycle latency).
REQ-015 an SHALL equal 1<<idx; exactly one bit set at all times outside reset.
REQ-016 Digit map: idx0..4 -> num_s nibbles [19:16],[15:12],[11:8],[7:4],[3:0]; idx5 -> blank; idx6 -> tens of times_s; idx7 -> units of times_s.
REQ-017 Tens digit SHALL be blank when times_s<10, else show 1; units = times_s mod 10.
REQ-018 Encoding seg[6:0]: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; num nibble 10..15 = 40 (dash); blank = 00; seg[7] (dp) always 0.
REQ-019 frame_cnt SHALL count frame ends 0..BLINK_FRAMES-1; at wrap blink_on toggles.
REQ-020 When warn_s==1 and blink_on==0, seg SHALL be 00 for every digit while an keeps scanning.
REQ-021 While warn_s==0, blink_on SHALL be held at 1 and frame_cnt at 0, so a new warning starts with a full visible half-period.
REQ-022 Snapshot load and blink update coinciding on one frame-end tick SHALL both take effect; blink logic uses the newly loaded warn_s from the next cycle.
REQ-023 Input changes SHALL have no effect on an/seg until the next snapshot load.

Reset
REQ-024 While rst_n==0: an=00, seg=00, scan_cnt=0, idx=0, frame_cnt=0, blink_on=1, num_s=0, times_s=0, warn_s=0.
REQ-025 Reset assertion mid-frame SHALL clear all state immediately (asynchronous), with no glitch pulse on an.
REQ-026 First cycle after release: an=01, seg=3F (idx0 of cleared snapshot) appear one edge later; snapshot loads in that same edge.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 num_in=12345, times_in=7, warn_in=0, release reset -> an sequence 01,02,...,80 each held 4 cycles; seg 06,5B,4F,66,6D,00,00,07.
REQ-028 times_in=12 -> idx6 seg=06, idx7 seg=5B; times_in=0 -> idx6 00, idx7 3F.
REQ-029 num_in=1F3A0 (nibbles 1,F,3,A,0) -> idx0..4 seg 06,40,4F,40,3F.
REQ-030 Change num_in from 12345 to 54321 while idx==2 -> idx3,4 still show 4,5; 54321 appears from next frame's idx0.
REQ-031 warn_in=1 held -> 2 frames normal digits, 2 frames seg=00 with an scanning, repeating; warn_in=0 -> normal from next frame, no blank frames.
REQ-032 Assert rst_n=0 at idx==5 mid-slot -> an=00, seg=00 same cycle; release -> REQ-026 behaviour.
